ext_mem_sequencer: RTL and testbench

- Hardware replacement for the host-driven load / run / readback sequence of the multicore processor top.
- Accepts commands and a word stream, then drives the top's external memory ports:
  - writes instruction images into the IRAM of any of NUM_CORES cores, or data into the shared DRAM;
  - starts the processor for a programmed cycle count;
  - streams a DRAM address range back out.
- Sits between a host/UART bridge and the processor top. It owns every external-access strobe and mode line.

---
 rtl/ext_mem_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_ext_mem_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_sequencer.sv
// Command-driven sequencer for the processor top's external memory ports:
// IRAM/DRAM image loads, timed run, and DRAM readback streaming.
module ext_mem_sequencer #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 2,
  parameter int WE_CYC    = 4,
  parameter int HOLD_CYC  = 4,
  parameter int READ_LAT  = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_core,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [ADDR_W:0]      cmd_len,
  input  logic [31:0]          cmd_cycles,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W-1:0]    addr_ext,
  output logic [DATA_W-1:0]    data_ext,
  output logic [NUM_CORES-1:0] iram_write_ext,
  output logic                 dram_write_ext,
  output logic                 read_en_ext,
  input  logic [DATA_W-1:0]    dram_rd_data,
  output logic                 start_run,
  output logic                 start_iram,
  output logic                 start_dram,
  output logic                 start_read,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_DATA, S_SETUP, S_STROBE, S_HOLD,
    S_RUN, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_FINISH
  } state_t;

  typedef logic [ADDR_W:0] len_t;

  localparam logic [1:0] OP_IRAM = 2'd0;
  localparam logic [1:0] OP_DRAM = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] WE_LAST    = 32'(WE_CYC - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);
  localparam logic [31:0] RLAT_LAST  = 32'(READ_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [3:0]          core_q, core_d;
  len_t                len_q, len_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  len_t                words_q, words_d;
  logic [31:0]         tmr_q, tmr_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                err_q, err_d;

  logic [31:0]         tmr_inc;
  len_t                words_inc;
  logic                active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      core_q  <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
      tmr_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      core_q  <= core_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign tmr_inc   = tmr_q + 32'd1;
  assign words_inc = words_q + len_t'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    core_d  = core_q;
    len_d   = len_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          core_d  = cmd_core;
          len_d   = cmd_len;
          cyc_d   = cmd_cycles;
          addr_d  = cmd_addr;
          words_d = '0;
          tmr_d   = '0;
          // Out-of-range core is refused before any mode line moves
          if (cmd_op == OP_IRAM && 32'(cmd_core) >= 32'(NUM_CORES))
            err_d = 1'b1;
          else if (cmd_op == OP_RUN)
            state_d = (cmd_cycles == '0) ? S_FINISH : S_RUN;
          else if (cmd_len == '0)
            state_d = S_FINISH;
          else if (cmd_op == OP_READ)
            state_d = S_RD_REQ;
          else
            state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (wr_valid) begin
          data_d  = wr_data;
          tmr_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_d = tmr_inc;
        if (tmr_q == SETUP_LAST) begin
          tmr_d   = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        tmr_d = tmr_inc;
        if (tmr_q == WE_LAST) begin
          tmr_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        tmr_d = tmr_inc;
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_inc;
          state_d = (words_inc == len_q) ? S_FINISH : S_WAIT_DATA;
        end
      end
      S_RUN: begin
        tmr_d = tmr_inc;
        if (tmr_q == cyc_q - 32'd1) state_d = S_FINISH;
      end
      S_RD_REQ: begin
        tmr_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tmr_d = tmr_inc;
        if (tmr_q == RLAT_LAST) begin
          rd_d    = dram_rd_data;
          state_d = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (rd_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_inc;
          state_d = (words_inc == len_q) ? S_FINISH : S_RD_REQ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active = (state_q != S_IDLE) && (state_q != S_FINISH);

  always_comb begin
    cmd_ready      = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_FINISH);
    err            = err_q;
    wr_ready       = (state_q == S_WAIT_DATA);
    rd_valid       = (state_q == S_RD_OUT);
    rd_data        = rd_q;
    addr_ext       = addr_q;
    data_ext       = data_q;
    read_en_ext    = (state_q == S_RD_WAIT) || (state_q == S_RD_OUT);
    start_iram     = active && (op_q == OP_IRAM);
    start_dram     = active && (op_q == OP_DRAM);
    start_run      = active && (op_q == OP_RUN);
    start_read     = active && (op_q == OP_READ);
    iram_write_ext = '0;
    dram_write_ext = 1'b0;
    if (state_q == S_STROBE) begin
      if (op_q == OP_IRAM) iram_write_ext = NUM_CORES'(1) << core_q;
      if (op_q == OP_DRAM) dram_write_ext = 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_mem_sequencer.sv
// Scoreboard bench for ext_mem_sequencer: directed plan items plus
// randomized commands checked against an event-level reference model.
module tb_ext_mem_sequencer;

  localparam int NUM_CORES = 2;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int WE_CYC    = 4;
  localparam int AMOD      = 1 << ADDR_W;

  localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3, K_RUN = 4;

  logic                 clock = 0;
  logic                 reset_n = 0;
  logic                 cmd_valid = 0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = 0;
  logic [3:0]           cmd_core = 0;
  logic [ADDR_W-1:0]    cmd_addr = 0;
  logic [ADDR_W:0]      cmd_len = 0;
  logic [31:0]          cmd_cycles = 0;
  logic [DATA_W-1:0]    wr_data = 0;
  logic                 wr_valid = 0;
  logic                 wr_ready;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;
  logic                 rd_ready = 0;
  logic [ADDR_W-1:0]    addr_ext;
  logic [DATA_W-1:0]    data_ext;
  logic [NUM_CORES-1:0] iram_write_ext;
  logic                 dram_write_ext;
  logic                 read_en_ext;
  logic [DATA_W-1:0]    dram_rd_data;
  logic                 start_run, start_iram, start_dram, start_read;
  logic                 busy, done, err;

  ext_mem_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_core(cmd_core), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_cycles(cmd_cycles),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .addr_ext(addr_ext), .data_ext(data_ext),
    .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .dram_rd_data(dram_rd_data),
    .start_run(start_run), .start_iram(start_iram),
    .start_dram(start_dram), .start_read(start_read),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // DRAM model: every location reads back as its address times three
  assign dram_rd_data = DATA_W'(int'(addr_ext) * 3);

  typedef struct {
    int kind;
    int tgt;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  rd_hs = 0;
  int  stall_cnt = 0;
  bit  stall_next = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void push(int k, int t, int a, int d);
    ev_t e;
    e.kind = k; e.tgt = t; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(int k, int t, int a, int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", k, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", k, e.kind);
    if (k != e.kind) return;
    if (k == K_WR) begin
      chk("write_target", t, e.tgt);
      chk("write_addr", a, e.addr);
      chk("write_data", d, e.data);
    end else if (k == K_RD || k == K_RUN) begin
      chk(k == K_RD ? "read_data" : "run_length", d, e.data);
    end
  endtask

  // Monitor: turns pin activity into events and compares them in order
  bit in_wr = 0, in_run = 0, prev_stall = 0;
  int wr_w = 0, run_w = 0, w_addr = 0, w_data = 0;
  logic [DATA_W-1:0] prev_rd = 0;

  always @(negedge clock) begin
    logic [NUM_CORES:0] strb;
    int t;
    strb = {dram_write_ext, iram_write_ext};
    if (!reset_n) begin
      in_wr = 0; in_run = 0; prev_stall = 0; wr_w = 0; run_w = 0;
    end else begin
      chk("mode_onehot0",
          int'($onehot0({start_run, start_iram, start_dram, start_read})), 1);
      if (strb != 0) begin
        chk("strobe_onehot", int'($onehot(strb)), 1);
        if (!in_wr) begin
          t = NUM_CORES;
          for (int i = 0; i < NUM_CORES; i++)
            if (iram_write_ext[i]) t = i;
          in_wr = 1; wr_w = 1;
          w_addr = int'(addr_ext); w_data = int'(data_ext);
          pop_check(K_WR, t, w_addr, w_data);
        end else begin
          wr_w++;
          chk("strobe_addr_stable", int'(addr_ext), w_addr);
          chk("strobe_data_stable", int'(data_ext), w_data);
        end
      end else if (in_wr) begin
        in_wr = 0;
        chk("strobe_width", wr_w, WE_CYC);
      end
      if (wr_ready) chk("strobes_low_in_wait", int'(strb), 0);
      if (start_run) begin
        in_run = 1; run_w++;
      end else if (in_run) begin
        pop_check(K_RUN, 0, 0, run_w);
        in_run = 0; run_w = 0;
      end
      if (prev_stall) begin
        chk("rd_valid_held", int'(rd_valid), 1);
        chk("rd_data_held", int'(rd_data), int'(prev_rd));
        chk("read_en_held", int'(read_en_ext), 1);
      end
      if (rd_valid && rd_ready) begin
        pop_check(K_RD, 0, 0, int'(rd_data));
        rd_hs++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_rd = rd_data;
      if (done) pop_check(K_DONE, 0, 0, 0);
      if (err)  pop_check(K_ERR, 0, 0, 0);
    end
  end

  // Readback consumer: random backpressure with an optional long stall
  always @(posedge clock) begin
    #1;
    if (stall_next && rd_valid) begin
      stall_next = 0;
      stall_cnt = 10;
    end
    if (stall_cnt > 0) begin
      rd_ready = 0;
      stall_cnt--;
    end else begin
      rd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 0, 1);
  endtask

  task automatic send_cmd(int op, int core, int addr, int len, int cyc);
    wait_idle();
    @(posedge clock); #1;
    cmd_op = 2'(op); cmd_core = 4'(core); cmd_addr = ADDR_W'(addr);
    cmd_len = (ADDR_W+1)'(len); cmd_cycles = 32'(cyc);
    cmd_valid = 1;
    @(posedge clock); #1;
    cmd_valid = 0;
  endtask

  task automatic feed_word(int w, int gap);
    int n = 0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
    wr_data = DATA_W'(w);
    wr_valid = 1;
    @(negedge clock);
    while (!wr_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) chk("wr_ready_timeout", 0, 1);
    @(posedge clock); #1;
    wr_valid = 0;
    wr_data = DATA_W'($urandom);
  endtask

  // Reference model: a command expands into its ordered list of events
  task automatic do_load(int op, int core, int addr, int len, int fixed_gap);
    int words[$];
    int tgt;
    bit bad;
    bad = (op == 0) && (core >= NUM_CORES);
    tgt = (op == 0) ? core : NUM_CORES;
    for (int i = 0; i < len; i++) words.push_back(int'($urandom_range(0, 65535)));
    if (bad) begin
      push(K_ERR, 0, 0, 0);
    end else begin
      for (int i = 0; i < len; i++) push(K_WR, tgt, (addr + i) % AMOD, words[i]);
      push(K_DONE, 0, 0, 0);
    end
    send_cmd(op, core, addr, len, 0);
    if (!bad)
      for (int i = 0; i < len; i++)
        feed_word(words[i], fixed_gap >= 0 ? (i == 0 ? 0 : fixed_gap)
                                           : int'($urandom_range(0, 3)));
  endtask

  task automatic do_run(int cyc);
    if (cyc > 0) push(K_RUN, 0, 0, cyc);
    push(K_DONE, 0, 0, 0);
    send_cmd(2, 0, 0, 0, cyc);
  endtask

  task automatic do_read(int addr, int len);
    for (int i = 0; i < len; i++)
      push(K_RD, 0, 0, (((addr + i) % AMOD) * 3) & 16'hFFFF);
    push(K_DONE, 0, 0, 0);
    send_cmd(3, 0, addr, len, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_outputs_zero", int'({busy, done, err, wr_ready, rd_valid,
        read_en_ext, dram_write_ext, iram_write_ext, start_run, start_iram,
        start_dram, start_read, addr_ext, data_ext, rd_data} != 0), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1;

    push(K_WR, NUM_CORES, 100, 16'hABCD);
    send_cmd(1, 0, 100, 2, 0);
    feed_word(16'hABCD, 0);
    n = 0;
    @(negedge clock);
    while (!dram_write_ext && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reset_test_strobe_seen", int'(dram_write_ext), 1);
    #2 reset_n = 0;
    #1;
    chk("async_reset_strobes", int'({dram_write_ext, iram_write_ext}), 0);
    chk("async_reset_modes",
        int'({start_run, start_iram, start_dram, start_read}), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);
    exp_q.delete();

    do_load(0, 1, 1, 3, 0);

    push(K_ERR, 0, 0, 0);
    send_cmd(0, 2, 7, 3, 0);
    chk("reject_err_pulse", int'(err), 1);
    chk("reject_no_mode", int'(start_iram), 0);

    push(K_DONE, 0, 0, 0);
    send_cmd(1, 0, 40, 0, 0);
    chk("zero_len_done_next_cycle", int'(done), 1);

    do_load(1, 0, 511, 2, 7);

    do_run(100);

    do_read(5, 4);
    n = 0;
    @(negedge clock);
    while (rd_hs < 1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("first_read_seen", int'(rd_hs >= 1), 1);
    stall_next = 1;

    for (int k = 0; k < 14; k++) begin
      int op, core, addr, len, cyc;
      op   = int'($urandom_range(0, 3));
      core = int'($urandom_range(0, NUM_CORES));
      addr = int'($urandom_range(0, AMOD - 1));
      len  = int'($urandom_range(0, 4));
      cyc  = int'($urandom_range(0, 30));
      case (op)
        0, 1:    do_load(op, core, addr, len, -1);
        2:       do_run(cyc);
        default: do_read(addr, len);
      endcase
    end

    wait_idle();
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
